// File: rtl/vram_write_arbiter_if.sv
// VIDEORAM write-port bundle: two requesters, clear control and the RAM write bus.
interface vram_write_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              gnt1;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;

  // Requesters and the clear initiator drive this side.
  modport master (
    output req0, addr0, data0, req1, addr1, data1, clr_start,
    input  gnt0, gnt1, clr_busy, clr_done, ram_waddr, ram_wdata, ram_wen
  );

  // The arbiter owns grants, clear status and the RAM write port.
  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, clr_start,
    output gnt0, gnt1, clr_busy, clr_done, ram_waddr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Owns the single VIDEORAM write port: round-robin sharing between two
// requesters plus a clear sequencer that fills addresses 0..DEPTH-1.
module vram_write_arbiter #(
  parameter int unsigned          ADDR_W      = 4,
  parameter int unsigned          DATA_W      = 8,
  parameter int unsigned          DEPTH       = 16,
  parameter logic [DATA_W-1:0]    CLEAR_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  vram_write_arbiter_if.slave   bus
);

  // One extra bit so a full 2**ADDR_W clear can reach its terminal count.
  localparam int unsigned        CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;     // most recent contended winner (1 = requester 1)
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_clr_busy;
  logic              r_clr_done;

  logic w_req0;
  logic w_req1;
  logic w_both;
  logic w_sel0;
  logic w_sel1;
  logic w_arb_en;

  // A request seen in its own grant cycle is stale; masking lets requesters drop late.
  always_comb begin
    w_req0   = bus.req0 & ~r_gnt0;
    w_req1   = bus.req1 & ~r_gnt1;
    w_both   = w_req0 & w_req1;
    w_sel0   = w_req0 & (~w_req1 | r_last);
    w_sel1   = w_req1 & ~w_sel0;
    // Arbitrate when idle without a clear request, or on the clear's closing edge.
    w_arb_en = ((r_state == ST_ARB) && !bus.clr_start) ||
               ((r_state == ST_CLEAR) && (r_cnt == DEPTH_C));
  end

  // Arbitration and clear sequencing; every output is a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_ARB;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_wen      <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_clr_done <= 1'b0;

      case (r_state)
        ST_ARB: begin
          if (bus.clr_start) begin
            r_state    <= ST_CLEAR;
            r_wen      <= 1'b1;
            r_waddr    <= '0;
            r_wdata    <= CLEAR_VALUE;
            r_cnt      <= CNT_W'(1);
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == DEPTH_C) begin
            r_state    <= ST_ARB;
            r_cnt      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_wen   <= 1'b1;
            r_waddr <= ADDR_W'(r_cnt);
            r_wdata <= CLEAR_VALUE;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_ARB;
      endcase

      if (w_arb_en) begin
        if (w_sel0) begin
          r_gnt0  <= 1'b1;
          r_wen   <= 1'b1;
          r_waddr <= bus.addr0;
          r_wdata <= bus.data0;
        end else if (w_sel1) begin
          r_gnt1  <= 1'b1;
          r_wen   <= 1'b1;
          r_waddr <= bus.addr1;
          r_wdata <= bus.data1;
        end
        if (w_both) begin
          r_last <= w_sel1;
        end
      end
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.ram_wen   = r_wen;
  assign bus.ram_waddr = r_waddr;
  assign bus.ram_wdata = r_wdata;
  assign bus.clr_busy  = r_clr_busy;
  assign bus.clr_done  = r_clr_done;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed and randomised checks of the VIDEORAM write arbiter.
module tb_vram_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vram_write_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  vram_write_arbiter #(
    .ADDR_W(4), .DATA_W(8), .DEPTH(16), .CLEAR_VALUE(8'h00)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, bus.gnt0, 0);
    check({tag, "_gnt1"}, bus.gnt1, 0);
    check({tag, "_wen"}, bus.ram_wen, 0);
    check({tag, "_waddr"}, bus.ram_waddr, 0);
    check({tag, "_wdata"}, bus.ram_wdata, 0);
    check({tag, "_busy"}, bus.clr_busy, 0);
    check({tag, "_done"}, bus.clr_done, 0);
  endtask

  // Random-phase state
  logic [7:0] tb_ram [16];
  logic [7:0] mdl    [16];
  logic       m_busy;
  int         m_cnt;
  int         age0;
  int         age1;

  // One random-phase cycle: advance, update model, check, then drive new stimulus.
  task automatic rand_step(input bit allow_new);
    logic p_clr, p_req0, p_req1, m_wr;
    p_clr  = bus.clr_start;
    p_req0 = bus.req0;
    p_req1 = bus.req1;
    tick();
    if (bus.ram_wen) tb_ram[bus.ram_waddr] = bus.ram_wdata;
    m_wr = 1'b0;
    if (m_busy) begin
      if (m_cnt == 16) m_busy = 1'b0;
      else begin
        mdl[m_cnt] = 8'h00;
        m_cnt++;
        m_wr = 1'b1;
      end
    end else if (p_clr) begin
      m_busy = 1'b1;
      mdl[0] = 8'h00;
      m_cnt  = 1;
      m_wr   = 1'b1;
    end
    check("r_busy", bus.clr_busy, m_busy);
    check("r_gnt_excl", bus.gnt0 & bus.gnt1, 0);
    check("r_gnt_in_clr", (bus.gnt0 | bus.gnt1) & bus.clr_busy, 0);
    check("r_wen", bus.ram_wen, m_wr | bus.gnt0 | bus.gnt1);
    if (bus.gnt0) begin
      check("r_g0_req", p_req0, 1);
      check("r_g0_addr", bus.ram_waddr, bus.addr0);
      check("r_g0_data", bus.ram_wdata, bus.data0);
      mdl[bus.addr0] = bus.data0;
      bus.req0 = 1'b0;
      age0 = 0;
    end
    if (bus.gnt1) begin
      check("r_g1_req", p_req1, 1);
      check("r_g1_addr", bus.ram_waddr, bus.addr1);
      check("r_g1_data", bus.ram_wdata, bus.data1);
      mdl[bus.addr1] = bus.data1;
      bus.req1 = 1'b0;
      age1 = 0;
    end
    if (allow_new && !bus.req0 && $urandom_range(0, 2) == 0) begin
      bus.req0  = 1'b1;
      bus.addr0 = 4'($urandom_range(0, 15));
      bus.data0 = 8'($urandom);
    end
    if (allow_new && !bus.req1 && $urandom_range(0, 2) == 0) begin
      bus.req1  = 1'b1;
      bus.addr1 = 4'($urandom_range(0, 15));
      bus.data1 = 8'($urandom);
    end
    if (bus.req0) age0++;
    if (bus.req1) age1++;
    if (age0 > 80) begin
      check("r_starve0", age0, 0);
      age0 = 0;
    end
    if (age1 > 80) begin
      check("r_starve1", age1, 0);
      age1 = 0;
    end
    bus.clr_start = allow_new && ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int dones;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.req0      = 1'b0;
    bus.addr0     = '0;
    bus.data0     = '0;
    bus.req1      = 1'b0;
    bus.addr1     = '0;
    bus.data1     = '0;
    bus.clr_start = 1'b0;

    // 1: reset state, then single request held one extra edge
    #12;
    check_all_zero("rst");
    bus.req0  = 1'b1;
    bus.addr0 = 4'd3;
    bus.data0 = 8'h2A;
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_gnt0", bus.gnt0, 1);
    check("t1_wen", bus.ram_wen, 1);
    check("t1_waddr", bus.ram_waddr, 3);
    check("t1_wdata", bus.ram_wdata, 8'h2A);
    tick();
    check("t1_wen_off", bus.ram_wen, 0);
    check("t1_gnt0_off", bus.gnt0, 0);
    bus.req0 = 1'b0;
    tick();
    check("t1_idle_wen", bus.ram_wen, 0);

    // 2: both requesters held -> alternating grants starting with 0
    do_reset();
    bus.req0  = 1'b1; bus.addr0 = 4'd1; bus.data0 = 8'h11;
    bus.req1  = 1'b1; bus.addr1 = 4'd2; bus.data1 = 8'h22;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_gnt0", bus.gnt0, (i % 2 == 0) ? 1 : 0);
      check("t2_gnt1", bus.gnt1, (i % 2 == 1) ? 1 : 0);
      check("t2_wen", bus.ram_wen, 1);
      check("t2_waddr", bus.ram_waddr, (i % 2 == 0) ? 1 : 2);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check("t2_wen_off", bus.ram_wen, 0);

    // 3: clear start beats a simultaneous request; grant coincides with done
    bus.req1      = 1'b1; bus.addr1 = 4'd5; bus.data1 = 8'h77;
    bus.clr_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.clr_start = 1'b0;
      check("t3_wen", bus.ram_wen, 1);
      check("t3_waddr", bus.ram_waddr, i);
      check("t3_wdata", bus.ram_wdata, 0);
      check("t3_busy", bus.clr_busy, 1);
      check("t3_gnt1", bus.gnt1, 0);
      check("t3_done", bus.clr_done, 0);
    end
    tick();
    check("t3_done_end", bus.clr_done, 1);
    check("t3_gnt1_end", bus.gnt1, 1);
    check("t3_busy_end", bus.clr_busy, 0);
    check("t3_waddr_end", bus.ram_waddr, 5);
    check("t3_wdata_end", bus.ram_wdata, 8'h77);
    bus.req1 = 1'b0;
    tick();
    check("t3_done_off", bus.clr_done, 0);
    check("t3_wen_off", bus.ram_wen, 0);

    // 4: second clear start mid-sequence is ignored
    bus.clr_start = 1'b1;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      check("t4_waddr", bus.ram_waddr, i);
      if (bus.clr_done) dones++;
    end
    tick();
    check("t4_done", bus.clr_done, 1);
    if (bus.clr_done) dones++;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_busy_after", bus.clr_busy, 0);
      if (bus.clr_done) dones++;
    end
    check("t4_done_count", dones, 1);

    // 5: asynchronous reset mid-clear aborts with no done pulse
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_busy_pre", bus.clr_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.clr_done || bus.clr_busy) dones++;
    end
    check("t5_no_done", dones, 0);
    bus.req0 = 1'b1; bus.addr0 = 4'd9; bus.data0 = 8'h5A;
    tick();
    check("t5_gnt0", bus.gnt0, 1);
    check("t5_waddr", bus.ram_waddr, 9);
    check("t5_wdata", bus.ram_wdata, 8'h5A);
    bus.req0 = 1'b0;
    tick();

    // 6: random traffic against a RAM model
    for (int a = 0; a < 16; a++) begin
      tb_ram[a] = 8'hFF;
      mdl[a]    = 8'hFF;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
    age0   = 0;
    age1   = 0;
    bus.clr_start = 1'b1;
    for (int c = 0; c < 10000; c++) rand_step(1'b1);
    for (int c = 0; c < 100; c++) rand_step(1'b0);
    check("r_drained0", bus.req0, 0);
    check("r_drained1", bus.req1, 0);
    for (int a = 0; a < 16; a++) check("r_ram", tb_ram[a], mdl[a]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
